trdb_apb_regif: RTL and testbench

- APB3 responder that is the bus-side writer/reader for the trace encoder's memory-mapped configuration.
- It decodes host APB transfers into the encoder control and configuration fields and drives them as registered outputs to the encoder datapath: trace enable, packet_emitter option bits and the resync threshold.
- It returns status on reads and protects configuration from change while tracing is active.

---
 rtl/trdb_apb_regif.sv | 127 ++++++++++++
 tb/tb_trdb_apb_regif.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/trdb_apb_regif.sv
// APB3 configuration register block for the trace encoder: CTRL/CFG/RESYNC/STATUS.
// Every transfer takes one wait state; CFG and RESYNC are locked while tracing or busy.
module trdb_apb_regif #(
    parameter int                  ADDR_W     = 4,
    parameter int                  RESYNC_W   = 16,
    parameter logic [RESYNC_W-1:0] RESYNC_RST = 16'hFFFF
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [ADDR_W-1:0]   paddr_i,
    input  logic                psel_i,
    input  logic                penable_i,
    input  logic                pwrite_i,
    input  logic [31:0]         pwdata_i,
    output logic [31:0]         prdata_o,
    output logic                pready_o,
    output logic                pslverr_o,
    input  logic                encoder_busy_i,
    output logic                trace_activated_o,
    output logic                nocontext_o,
    output logic                notime_o,
    output logic                encoder_mode_o,
    output logic                delta_address_o,
    output logic                full_address_o,
    output logic                implicit_exception_o,
    output logic                sijump_o,
    output logic                implicit_return_o,
    output logic                branch_prediction_o,
    output logic                jump_target_cache_o,
    output logic [RESYNC_W-1:0] resync_max_o,
    output logic                cfg_update_o
);

    localparam int WD = (RESYNC_W > 10) ? RESYNC_W : 10;

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    state_t              r_state;
    logic [3:0]          r_addr;
    logic                r_write;
    logic [31:0]         r_wdata;
    logic                r_ctrl;
    logic [9:0]          r_cfg;
    logic [RESYNC_W-1:0] r_resync;
    logic                r_cfg_update;

    logic        w_access;
    logic        w_cfg_reg;
    logic        w_err;
    logic        w_commit;
    logic [31:0] w_rdata;
    logic        w_unused;

    // Abort on a dropped psel/penable makes pready combinational on the live bus.
    assign w_access  = (r_state == S_ACCESS) && psel_i && penable_i;
    assign w_cfg_reg = (r_addr[3:2] == 2'd1) || (r_addr[3:2] == 2'd2);
    assign w_err     = (r_addr[1:0] != 2'b00)
                     || (r_write && (r_addr[3:2] == 2'd3))
                     || (r_write && w_cfg_reg && (r_ctrl || encoder_busy_i));
    assign w_commit  = w_access && r_write && !w_err;
    assign w_unused  = ^r_wdata[31:WD];

    always_comb begin
        w_rdata = '0;
        case (r_addr[3:2])
            2'd0:    w_rdata = {31'b0, r_ctrl};
            2'd1:    w_rdata = {22'b0, r_cfg};
            2'd2:    w_rdata = 32'(r_resync);
            default: w_rdata = {30'b0, r_ctrl, encoder_busy_i};
        endcase
    end

    assign pready_o  = w_access;
    assign pslverr_o = w_access && w_err;
    assign prdata_o  = (w_access && !r_write && !w_err) ? w_rdata : 32'b0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_addr       <= '0;
            r_write      <= 1'b0;
            r_wdata      <= '0;
            r_ctrl       <= 1'b0;
            r_cfg        <= '0;
            r_resync     <= RESYNC_RST;
            r_cfg_update <= 1'b0;
        end else begin
            r_cfg_update <= w_commit && w_cfg_reg;
            case (r_state)
                S_IDLE: begin
                    if (psel_i && penable_i) begin
                        r_addr  <= paddr_i[3:0];
                        r_write <= pwrite_i;
                        r_wdata <= pwdata_i;
                        r_state <= S_ACCESS;
                    end
                end
                default: begin
                    if (w_commit) begin
                        case (r_addr[3:2])
                            2'd0:    r_ctrl   <= r_wdata[0];
                            2'd1:    r_cfg    <= r_wdata[9:0];
                            2'd2:    r_resync <= r_wdata[RESYNC_W-1:0];
                            default: ;
                        endcase
                    end
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign trace_activated_o    = r_ctrl;
    assign nocontext_o          = r_cfg[0];
    assign notime_o             = r_cfg[1];
    assign encoder_mode_o       = r_cfg[2];
    assign delta_address_o      = r_cfg[3];
    assign full_address_o       = r_cfg[4];
    assign implicit_exception_o = r_cfg[5];
    assign sijump_o             = r_cfg[6];
    assign implicit_return_o    = r_cfg[7];
    assign branch_prediction_o  = r_cfg[8];
    assign jump_target_cache_o  = r_cfg[9];
    assign resync_max_o         = r_resync;
    assign cfg_update_o         = r_cfg_update;

endmodule

// File: tb/tb_trdb_apb_regif.sv
// Directed bench for trdb_apb_regif: expected responses queued per transfer,
// compared when pready is seen.
module tb_trdb_apb_regif;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic [3:0]  paddr_i = '0;
    logic        psel_i = 1'b0;
    logic        penable_i = 1'b0;
    logic        pwrite_i = 1'b0;
    logic [31:0] pwdata_i = '0;
    logic [31:0] prdata_o;
    logic        pready_o;
    logic        pslverr_o;
    logic        encoder_busy_i = 1'b0;
    logic        trace_activated_o;
    logic        nocontext_o, notime_o, encoder_mode_o, delta_address_o, full_address_o;
    logic        implicit_exception_o, sijump_o, implicit_return_o, branch_prediction_o;
    logic        jump_target_cache_o;
    logic [15:0] resync_max_o;
    logic        cfg_update_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        upd;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    trdb_apb_regif dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .paddr_i(paddr_i), .psel_i(psel_i),
        .penable_i(penable_i), .pwrite_i(pwrite_i), .pwdata_i(pwdata_i),
        .prdata_o(prdata_o), .pready_o(pready_o), .pslverr_o(pslverr_o),
        .encoder_busy_i(encoder_busy_i), .trace_activated_o(trace_activated_o),
        .nocontext_o(nocontext_o), .notime_o(notime_o), .encoder_mode_o(encoder_mode_o),
        .delta_address_o(delta_address_o), .full_address_o(full_address_o),
        .implicit_exception_o(implicit_exception_o), .sijump_o(sijump_o),
        .implicit_return_o(implicit_return_o), .branch_prediction_o(branch_prediction_o),
        .jump_target_cache_o(jump_target_cache_o), .resync_max_o(resync_max_o),
        .cfg_update_o(cfg_update_o)
    );

    always #5 clk_i = ~clk_i;

    wire [9:0] opts = {jump_target_cache_o, branch_prediction_o, implicit_return_o, sijump_o,
                       implicit_exception_o, full_address_o, delta_address_o, encoder_mode_o,
                       notime_o, nocontext_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transfer: setup, enable; pready must be low on the 1st enable cycle.
    task automatic xfer(input string tag, input logic [3:0] a, input logic wr,
                        input logic [31:0] d, input exp_t e);
        exp_t got;
        int   n;
        exp_q.push_back(e);
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = a; pwrite_i = wr; pwdata_i = d;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(negedge clk_i);
        chk({tag, "_wait"}, {31'b0, pready_o}, 32'd0);
        n = 0;
        do begin
            @(negedge clk_i);
            n++;
        end while (!pready_o && n < 6);
        got = exp_q.pop_front();
        chk({tag, "_ready_cyc"}, n, 1);
        chk({tag, "_err"}, {31'b0, pslverr_o}, {31'b0, got.err});
        chk({tag, "_rdata"}, prdata_o, got.rdata);
        chk({tag, "_upd_early"}, {31'b0, cfg_update_o}, 32'd0);
        @(posedge clk_i); #1;
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_upd"}, {31'b0, cfg_update_o}, {31'b0, got.upd});
        @(negedge clk_i);
        chk({tag, "_upd_once"}, {31'b0, cfg_update_o}, 32'd0);
    endtask

    function automatic exp_t E(input logic [31:0] r, input logic er, input logic u);
        exp_t e;
        e.rdata = r; e.err = er; e.upd = u;
        return e;
    endfunction

    initial begin
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_opts", {22'b0, opts}, 32'd0);
        chk("rst_resync", {16'b0, resync_max_o}, 32'h0000FFFF);
        chk("rst_ready", {29'b0, pready_o, pslverr_o, cfg_update_o}, 32'd0);
        chk("rst_rdata", prdata_o, 32'd0);
        rst_ni = 1'b1;

        xfer("rd_status", 4'hC, 1'b0, 32'hDEAD, E(32'h0, 1'b0, 1'b0));
        xfer("rd_resync", 4'h8, 1'b0, 32'h0, E(32'h0000FFFF, 1'b0, 1'b0));
        xfer("wr_cfg", 4'h4, 1'b1, 32'hFFFF_FFFF, E(32'h0, 1'b0, 1'b1));
        chk("cfg_opts", {22'b0, opts}, 32'h3FF);
        xfer("rd_cfg", 4'h4, 1'b0, 32'h0, E(32'h3FF, 1'b0, 1'b0));

        xfer("wr_ctrl1", 4'h0, 1'b1, 32'h1, E(32'h0, 1'b0, 1'b0));
        chk("trace_on", {31'b0, trace_activated_o}, 32'd1);
        xfer("wr_cfg_lock", 4'h4, 1'b1, 32'h1, E(32'h0, 1'b1, 1'b0));
        chk("cfg_locked", {22'b0, opts}, 32'h3FF);
        xfer("rd_status_tr", 4'hC, 1'b0, 32'h0, E(32'h2, 1'b0, 1'b0));
        encoder_busy_i = 1'b1;
        xfer("wr_ctrl0_busy", 4'h0, 1'b1, 32'h0, E(32'h0, 1'b0, 1'b0));
        chk("trace_off", {31'b0, trace_activated_o}, 32'd0);

        xfer("wr_rs_busy", 4'h8, 1'b1, 32'h1234, E(32'h0, 1'b1, 1'b0));
        chk("rs_locked", {16'b0, resync_max_o}, 32'hFFFF);
        xfer("rd_status_busy", 4'hC, 1'b0, 32'h0, E(32'h1, 1'b0, 1'b0));
        encoder_busy_i = 1'b0;
        xfer("wr_rs", 4'h8, 1'b1, 32'hABCD_1234, E(32'h0, 1'b0, 1'b1));
        chk("rs_new", {16'b0, resync_max_o}, 32'h1234);
        xfer("rd_rs", 4'h8, 1'b0, 32'h0, E(32'h1234, 1'b0, 1'b0));

        xfer("wr_status", 4'hC, 1'b1, 32'h3, E(32'h0, 1'b1, 1'b0));
        chk("status_nochg", {31'b0, trace_activated_o}, 32'd0);
        xfer("rd_misalign", 4'h2, 1'b0, 32'h0, E(32'h0, 1'b1, 1'b0));
        xfer("wr_misalign", 4'h6, 1'b1, 32'h0, E(32'h0, 1'b1, 1'b0));
        chk("misalign_nochg", {22'b0, opts}, 32'h3FF);

        // Abort: psel dropped during the wait state.
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 4'h4; pwrite_i = 1'b1; pwdata_i = 32'h0AA;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(posedge clk_i); #1;
        psel_i = 1'b0;
        @(negedge clk_i);
        chk("abort_ready", {31'b0, pready_o}, 32'd0);
        penable_i = 1'b0;
        @(negedge clk_i);
        chk("abort_upd", {31'b0, cfg_update_o}, 32'd0);
        chk("abort_cfg", {22'b0, opts}, 32'h3FF);
        xfer("rd_cfg_abort", 4'h4, 1'b0, 32'h0, E(32'h3FF, 1'b0, 1'b0));

        // Reset during the ACCESS cycle of a CFG write.
        @(posedge clk_i); #1;
        psel_i = 1'b1; penable_i = 1'b0; paddr_i = 4'h4; pwrite_i = 1'b1; pwdata_i = 32'h155;
        @(posedge clk_i); #1;
        penable_i = 1'b1;
        @(posedge clk_i); #1;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_opts", {22'b0, opts}, 32'd0);
        chk("rst_mid_rs", {16'b0, resync_max_o}, 32'hFFFF);
        chk("rst_mid_ready", {31'b0, pready_o}, 32'd0);
        psel_i = 1'b0; penable_i = 1'b0;
        @(negedge clk_i);
        chk("rst_mid_upd", {31'b0, cfg_update_o}, 32'd0);
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rst_mid_upd2", {31'b0, cfg_update_o}, 32'd0);
        xfer("rd_cfg_rst", 4'h4, 1'b0, 32'h0, E(32'h0, 1'b0, 1'b0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
